// File: rtl/io_pkg.sv
// Shared register map, load/store size codes and bus lane helpers for the
// memory-mapped switch/LED/timer IO block.
package io_pkg;

  typedef enum logic [2:0] {
    REG_SW     = 3'd0,
    REG_LED    = 3'd1,
    REG_TCOUNT = 3'd2,
    REG_TCMP   = 3'd3,
    REG_TCTRL  = 3'd4,
    REG_TSTAT  = 3'd5
  } reg_sel_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AR   = 1;
  localparam int TSTAT_PEND = 0;

  // Byte enables of a store; unsupported sizes produce no enables at all.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_B:    store_be = 4'b0001 << lane;
      F3_H:    store_be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Replicating the low data lets the byte enables pick the right lane.
  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    store_align = {4{wdata[7:0]}};
      F3_H:    store_align = {2{wdata[15:0]}};
      default: store_align = wdata;
    endcase
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    merge_be = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) merge_be[8*i +: 8] = new_v[8*i +: 8];
  endfunction

endpackage

// File: rtl/io_dev_gen_if.sv
// CPU-side load/store bus of the IO block.
interface io_dev_gen_if;
  logic [3:0]  cs;
  logic [4:0]  addr;
  logic [2:0]  funct3;
  logic        mem_write;
  logic [31:0] wdata;
  logic [31:0] data_out;

  modport master (output cs, addr, funct3, mem_write, wdata, input data_out);
  modport slave  (input cs, addr, funct3, mem_write, wdata, output data_out);
endinterface

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a consecutive-cycle
// debounce counter that must see DEB_N differing cycles before accepting.
module sw_debounce #(
  parameter int DEB_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_stable
);
  localparam int CW = (DEB_N < 2) ? 1 : $clog2(DEB_N);

  logic          sync_p0, sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      sw_stable <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_p0 <= sw_in;
      // stage boundary: synchronised value feeds the debounce counter
      sync_p1 <= sync_p0;
      if (sync_p1 == sw_stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_N - 1)) begin
        sw_stable <= sync_p1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/io_dev_gen.sv
// Memory-mapped IO device: debounced switches, LED register and a 32-bit
// compare timer with auto-reload and a write-1-clear pending interrupt.
module io_dev_gen
  import io_pkg::*;
#(
  parameter int         SW_W  = 8,
  parameter int         LED_W = 8,
  parameter int         DEB_N = 4,
  parameter logic [3:0] IO_CS = 4'd2
) (
  input  logic             clk,
  input  logic             reset,
  io_dev_gen_if.slave      bus,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] leds_out,
  output logic             irq
);

  logic             sel, wr_en, match;
  logic [2:0]       widx;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wd_al, rd_word;
  logic [7:0]       rd_b;
  logic [15:0]      rd_h;
  logic [SW_W-1:0]  sw_stable;
  logic [31:0]      tcount, tcmp;
  logic [1:0]       tctrl;
  logic             pending;

  for (genvar i = 0; i < SW_W; i++) begin : g_deb
    sw_debounce #(.DEB_N(DEB_N)) u_deb (
      .clk       (clk),
      .reset     (reset),
      .sw_in     (sw[i]),
      .sw_stable (sw_stable[i])
    );
  end

  assign sel   = (bus.cs == IO_CS);
  assign wr_en = sel && bus.mem_write;
  assign widx  = bus.addr[4:2];
  assign lane  = bus.addr[1:0];
  assign be    = store_be(bus.funct3, lane);
  assign wd_al = store_align(bus.funct3, bus.wdata);
  assign match = tctrl[TCTRL_EN] && (tcount == tcmp);
  assign irq   = pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_out <= '0;
      tcount   <= '0;
      tcmp     <= '1;
      tctrl    <= '0;
      pending  <= 1'b0;
    end else begin
      if (wr_en && widx == REG_LED)
        leds_out <= LED_W'(merge_be(32'(leds_out), wd_al, be));
      if (wr_en && widx == REG_TCMP)
        tcmp <= merge_be(tcmp, wd_al, be);
      if (wr_en && widx == REG_TCTRL)
        tctrl <= 2'(merge_be({30'd0, tctrl}, wd_al, be));
      // A bus write to the counter overrides both increment and reload
      if (wr_en && widx == REG_TCOUNT)
        tcount <= merge_be(tcount, wd_al, be);
      else if (tctrl[TCTRL_EN])
        tcount <= (match && tctrl[TCTRL_AR]) ? 32'd0 : tcount + 32'd1;
      if (match)
        pending <= 1'b1;
      else if (wr_en && widx == REG_TSTAT && be[0] && wd_al[TSTAT_PEND])
        pending <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    case (widx)
      REG_SW:     rd_word = 32'(sw_stable);
      REG_LED:    rd_word = 32'(leds_out);
      REG_TCOUNT: rd_word = tcount;
      REG_TCMP:   rd_word = tcmp;
      REG_TCTRL:  rd_word = {30'd0, tctrl};
      REG_TSTAT:  rd_word = {31'd0, pending};
      default:    rd_word = '0;
    endcase
    rd_b = 8'(rd_word >> {lane, 3'b000});
    rd_h = 16'(rd_word >> {lane[1], 4'b0000});
    bus.data_out = '0;
    if (sel) begin
      case (bus.funct3)
        F3_B:    bus.data_out = {{24{rd_b[7]}}, rd_b};
        F3_H:    bus.data_out = {{16{rd_h[15]}}, rd_h};
        F3_W:    bus.data_out = rd_word;
        F3_BU:   bus.data_out = {24'd0, rd_b};
        F3_HU:   bus.data_out = {16'd0, rd_h};
        default: bus.data_out = '0;
      endcase
    end
  end

endmodule
